// File: rtl/k423_pkg.sv
// ---------------------------------------------------------------------------
// k423_pkg
// Shared types and constants for the k423 ID-stage instruction queue.
//   id_q_entry_t           : one queued instruction plus its BPU prediction
//   K423_ID_Q_DEPTH_DFLT   : default queue depth
// CORE_ADDR_W / CORE_INST_W fall back to 32 bits when the core does not
// define them.
// ---------------------------------------------------------------------------
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef CORE_INST_W
`define CORE_INST_W 32
`endif

package k423_pkg;

    localparam int K423_ID_Q_DEPTH_DFLT = 4;

    typedef struct packed {
        logic [`CORE_ADDR_W-1:0] pc;
        logic [`CORE_INST_W-1:0] inst;
        logic                    prd_tkn;
        logic [`CORE_ADDR_W-1:0] prd_pc;
        logic [1:0]              prd_sat_cnt;
    } id_q_entry_t;

endpackage

// File: rtl/k423_fifo_ptr.sv
// ---------------------------------------------------------------------------
// k423_fifo_ptr
// Read/write pointer, occupancy and full/empty bookkeeping for a
// power-of-two FIFO. Storage lives in the instantiating module.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   flush_i        : clears pointers and count; wins over push/pop
//   push_i, pop_i  : already-qualified enqueue / dequeue strobes
//   wr_ptr_o       : slot the next push writes
//   rd_ptr_o       : slot holding the head
//   cnt_o          : occupancy (0..DEPTH)
//   full_o/empty_o : cnt_o == DEPTH / cnt_o == 0
// ---------------------------------------------------------------------------
module k423_fifo_ptr #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so +1 wraps on its own.
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign cnt_o    = cnt_q;
    assign full_o   = (cnt_q == CNT_W'(DEPTH));
    assign empty_o  = (cnt_q == '0);

endmodule

// File: rtl/k423_id_inst_queue.sv
// ---------------------------------------------------------------------------
// k423_id_inst_queue
// DEPTH-entry instruction FIFO between IF and the ID decoder. Carries each
// fetched instruction with its BPU prediction, decouples fetch from EX
// back-pressure, holds the head during hazard stalls and drops everything
// on flush.
//   clk_i, rst_n_i           : clock, synchronous active-low reset
//   if_stage_vld_i / id_stage_rdy_o : IF -> queue handshake
//   if_pc_i, if_inst_i, if_bpu_prd_* : offered payload
//   flush_i                  : discard queued and offered instructions
//   hazard_stall_i           : hold the head back from EX
//   id_stage_vld_o / ex_stage_rdy_i : queue -> EX handshake
//   id_pc_o, id_inst_o, id_bpu_prd_* : head payload
//   id_q_cnt_o               : occupancy
// Optional feature: define K423_ID_QUEUE_BYPASS_EN to let an empty queue
// forward the IF payload combinationally (0-cycle latency).
// ---------------------------------------------------------------------------
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef CORE_INST_W
`define CORE_INST_W 32
`endif

module k423_id_inst_queue
    import k423_pkg::*;
#(
    parameter int DEPTH = K423_ID_Q_DEPTH_DFLT,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    if_stage_vld_i,
    output logic                    id_stage_rdy_o,
    input  logic [`CORE_ADDR_W-1:0] if_pc_i,
    input  logic [`CORE_INST_W-1:0] if_inst_i,
    input  logic                    if_bpu_prd_tkn_i,
    input  logic [`CORE_ADDR_W-1:0] if_bpu_prd_pc_i,
    input  logic [1:0]              if_bpu_prd_sat_cnt_i,
    input  logic                    flush_i,
    input  logic                    hazard_stall_i,
    output logic                    id_stage_vld_o,
    input  logic                    ex_stage_rdy_i,
    output logic [`CORE_ADDR_W-1:0] id_pc_o,
    output logic [`CORE_INST_W-1:0] id_inst_o,
    output logic                    id_bpu_prd_tkn_o,
    output logic [`CORE_ADDR_W-1:0] id_bpu_prd_pc_o,
    output logic [1:0]              id_bpu_prd_sat_cnt_o,
    output logic [CNT_W-1:0]        id_q_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    id_q_entry_t      mem_q [DEPTH];
    id_q_entry_t      if_entry;
    id_q_entry_t      out_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;
    logic             push;
    logic             pop;

    assign if_entry = '{
        pc:          if_pc_i,
        inst:        if_inst_i,
        prd_tkn:     if_bpu_prd_tkn_i,
        prd_pc:      if_bpu_prd_pc_i,
        prd_sat_cnt: if_bpu_prd_sat_cnt_i
    };

    // Ready comes from the registered count only: a full queue refuses a
    // new instruction even when the head leaves in the same cycle.
    assign id_stage_rdy_o = ~full;
    assign enq            = if_stage_vld_i & ~full & ~flush_i;

`ifdef K423_ID_QUEUE_BYPASS_EN
    logic byp_act;

    // Empty queue forwards the IF offer straight to EX; if EX takes it the
    // entry never lands in storage.
    assign byp_act        = empty & ~flush_i;
    assign id_stage_vld_o = byp_act ? (if_stage_vld_i & ~hazard_stall_i)
                                    : (~empty & ~hazard_stall_i & ~flush_i);
    assign out_entry      = byp_act ? if_entry : mem_q[rd_ptr];
    assign deq            = id_stage_vld_o & ex_stage_rdy_i;
    assign push           = enq & ~(byp_act & deq);
    assign pop            = deq & ~byp_act;
`else
    assign id_stage_vld_o = ~empty & ~hazard_stall_i & ~flush_i;
    assign out_entry      = mem_q[rd_ptr];
    assign deq            = id_stage_vld_o & ex_stage_rdy_i;
    assign push           = enq;
    assign pop            = deq;
`endif

    k423_fifo_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_fifo_ptr (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .flush_i  (flush_i),
        .push_i   (push),
        .pop_i    (pop),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .cnt_o    (cnt),
        .full_o   (full),
        .empty_o  (empty)
    );

    // NOTE: storage is cleared on reset because the head payload is visible
    // on the outputs and must read as zero after reset; flush leaves the
    // contents alone since only pointers decide validity.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr] <= if_entry;
        end
    end

    assign id_pc_o              = out_entry.pc;
    assign id_inst_o            = out_entry.inst;
    assign id_bpu_prd_tkn_o     = out_entry.prd_tkn;
    assign id_bpu_prd_pc_o      = out_entry.prd_pc;
    assign id_bpu_prd_sat_cnt_o = out_entry.prd_sat_cnt;
    assign id_q_cnt_o           = cnt;

endmodule

// File: tb/tb_k423_id_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_k423_id_inst_queue
// Directed scenarios followed by random traffic. A queue of expected
// entries models the FIFO; a negedge monitor compares control outputs and
// the head payload against it and retires entries on each EX handshake.
// ---------------------------------------------------------------------------
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif
`ifndef CORE_INST_W
`define CORE_INST_W 32
`endif

module tb_k423_id_inst_queue;
    import k423_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                    clk_i = 1'b0;
    logic                    rst_n_i;
    logic                    if_stage_vld_i;
    logic                    id_stage_rdy_o;
    logic [`CORE_ADDR_W-1:0] if_pc_i;
    logic [`CORE_INST_W-1:0] if_inst_i;
    logic                    if_bpu_prd_tkn_i;
    logic [`CORE_ADDR_W-1:0] if_bpu_prd_pc_i;
    logic [1:0]              if_bpu_prd_sat_cnt_i;
    logic                    flush_i;
    logic                    hazard_stall_i;
    logic                    id_stage_vld_o;
    logic                    ex_stage_rdy_i;
    logic [`CORE_ADDR_W-1:0] id_pc_o;
    logic [`CORE_INST_W-1:0] id_inst_o;
    logic                    id_bpu_prd_tkn_o;
    logic [`CORE_ADDR_W-1:0] id_bpu_prd_pc_o;
    logic [1:0]              id_bpu_prd_sat_cnt_o;
    logic [CNT_W-1:0]        id_q_cnt_o;

    k423_id_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk_i                (clk_i),
        .rst_n_i              (rst_n_i),
        .if_stage_vld_i       (if_stage_vld_i),
        .id_stage_rdy_o       (id_stage_rdy_o),
        .if_pc_i              (if_pc_i),
        .if_inst_i            (if_inst_i),
        .if_bpu_prd_tkn_i     (if_bpu_prd_tkn_i),
        .if_bpu_prd_pc_i      (if_bpu_prd_pc_i),
        .if_bpu_prd_sat_cnt_i (if_bpu_prd_sat_cnt_i),
        .flush_i              (flush_i),
        .hazard_stall_i       (hazard_stall_i),
        .id_stage_vld_o       (id_stage_vld_o),
        .ex_stage_rdy_i       (ex_stage_rdy_i),
        .id_pc_o              (id_pc_o),
        .id_inst_o            (id_inst_o),
        .id_bpu_prd_tkn_o     (id_bpu_prd_tkn_o),
        .id_bpu_prd_pc_o      (id_bpu_prd_pc_o),
        .id_bpu_prd_sat_cnt_o (id_bpu_prd_sat_cnt_o),
        .id_q_cnt_o           (id_q_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    id_q_entry_t sb[$];
    bit          just_reset = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / monitor (negedge) ----------------
    always @(negedge clk_i) begin : monitor
        id_q_entry_t in_e;
        id_q_entry_t exp_e;
        bit          byp;
        bit          exp_vld;
        bit          exp_rdy;
        bit          deq;
        bit          enq;
        int          n;
        if (!rst_n_i) begin
            sb.delete();
            just_reset = 1'b1;
        end else begin
            in_e = '{pc: if_pc_i, inst: if_inst_i, prd_tkn: if_bpu_prd_tkn_i,
                     prd_pc: if_bpu_prd_pc_i, prd_sat_cnt: if_bpu_prd_sat_cnt_i};
            n       = sb.size();
            exp_rdy = (n != DEPTH);
            check("cnt", 64'(id_q_cnt_o), 64'(n));
            check("rdy", 64'(id_stage_rdy_o), 64'(exp_rdy));
`ifdef K423_ID_QUEUE_BYPASS_EN
            byp = (n == 0) && !flush_i;
`else
            byp = 1'b0;
`endif
            if (byp) begin
                exp_vld = if_stage_vld_i && !hazard_stall_i;
                exp_e   = in_e;
            end else begin
                exp_vld = (n != 0) && !hazard_stall_i && !flush_i;
                exp_e   = (n != 0) ? sb[0] : '0;
            end
            check("vld", 64'(id_stage_vld_o), 64'(exp_vld));
            if (exp_vld || just_reset) begin
                check("head_pc",   64'(id_pc_o),              64'(exp_e.pc));
                check("head_inst", 64'(id_inst_o),            64'(exp_e.inst));
                check("head_tkn",  64'(id_bpu_prd_tkn_o),     64'(exp_e.prd_tkn));
                check("head_ppc",  64'(id_bpu_prd_pc_o),      64'(exp_e.prd_pc));
                check("head_sat",  64'(id_bpu_prd_sat_cnt_o), 64'(exp_e.prd_sat_cnt));
            end
            just_reset = 1'b0;
            // advance the model across the coming edge
            if (flush_i) begin
                sb.delete();
            end else begin
                deq = exp_vld && ex_stage_rdy_i;
                enq = if_stage_vld_i && exp_rdy;
                if (deq && !byp) void'(sb.pop_front());
                if (enq && !(byp && deq)) sb.push_back(in_e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        if_stage_vld_i       = 1'b1;
        if_pc_i              = `CORE_ADDR_W'(pc);
        if_inst_i            = `CORE_INST_W'($urandom);
        if_bpu_prd_tkn_i     = 1'($urandom);
        if_bpu_prd_pc_i      = `CORE_ADDR_W'($urandom);
        if_bpu_prd_sat_cnt_i = 2'($urandom);
    endtask

    task automatic zero_inputs();
        if_stage_vld_i       = 1'b0;
        if_pc_i              = '0;
        if_inst_i            = '0;
        if_bpu_prd_tkn_i     = 1'b0;
        if_bpu_prd_pc_i      = '0;
        if_bpu_prd_sat_cnt_i = '0;
        flush_i              = 1'b0;
        hazard_stall_i       = 1'b0;
        ex_stage_rdy_i       = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n_i = 1'b0;
        zero_inputs();
        repeat (cycles) step();
        rst_n_i = 1'b1;
        step();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n_i = 1'b0;
        zero_inputs();
        do_reset(2);

        // Fill to DEPTH with EX stalled.
        for (int i = 0; i < 4; i++) begin
            offer(32'h100 + 32'(4 * i));
            step();
        end
        offer(32'h110);
        @(negedge clk_i);
        check("full_cnt", 64'(id_q_cnt_o), 64'd4);
        check("full_rdy", 64'(id_stage_rdy_o), 64'd0);
        check("full_head", 64'(id_pc_o), 64'h100);
        step();

        // Full with EX ready: this cycle only dequeues.
        ex_stage_rdy_i = 1'b1;
        @(negedge clk_i);
        check("full_deq_rdy", 64'(id_stage_rdy_o), 64'd0);
        step();
        for (int k = 0; k < 6; k++) begin
            offer(32'h110 + 32'(4 * k));
            @(negedge clk_i);
            check("steady_cnt", 64'(id_q_cnt_o), 64'd3);
            step();
        end

        // Hazard hold with head 0x200.
        zero_inputs();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        offer(32'h200); step();
        offer(32'h204); step();
        hazard_stall_i = 1'b1;
        ex_stage_rdy_i = 1'b1;
        offer(32'h20C);
        @(negedge clk_i);
        check("hz_vld", 64'(id_stage_vld_o), 64'd0);
        step();
        if_stage_vld_i = 1'b0;
        step();
        step();
        hazard_stall_i = 1'b0;
        @(negedge clk_i);
        check("hz_cnt", 64'(id_q_cnt_o), 64'd3);
        check("hz_head", 64'(id_pc_o), 64'h200);
        step();

        // Flush with cnt=3 and an offer pending.
        ex_stage_rdy_i = 1'b0;
        offer(32'h210); step();
        flush_i = 1'b1;
        offer(32'h214);
        @(negedge clk_i);
        check("fl_cnt_before", 64'(id_q_cnt_o), 64'd3);
        check("fl_vld", 64'(id_stage_vld_o), 64'd0);
        step();
        flush_i = 1'b0;
        offer(32'h300);
        @(negedge clk_i);
        check("fl_cnt_after", 64'(id_q_cnt_o), 64'd0);
        step();
        if_stage_vld_i = 1'b0;
        @(negedge clk_i);
        check("fl_head", 64'(id_pc_o), 64'h300);
        check("fl_head_vld", 64'(id_stage_vld_o), 64'd1);
        ex_stage_rdy_i = 1'b1;
        step();

        // Empty queue, push 0x400 with EX ready.
        offer(32'h400);
        @(negedge clk_i);
`ifdef K423_ID_QUEUE_BYPASS_EN
        check("byp_vld", 64'(id_stage_vld_o), 64'd1);
        check("byp_pc", 64'(id_pc_o), 64'h400);
`else
        check("nobyp_vld", 64'(id_stage_vld_o), 64'd0);
`endif
        step();
        if_stage_vld_i = 1'b0;
        @(negedge clk_i);
`ifdef K423_ID_QUEUE_BYPASS_EN
        check("byp_cnt", 64'(id_q_cnt_o), 64'd0);
`else
        check("nobyp_vld_n1", 64'(id_stage_vld_o), 64'd1);
        check("nobyp_pc_n1", 64'(id_pc_o), 64'h400);
`endif
        step();

        // One-cycle reset at cnt=2.
        ex_stage_rdy_i = 1'b0;
        offer(32'h500); step();
        offer(32'h504); step();
        if_stage_vld_i = 1'b0;
        @(negedge clk_i);
        check("pre_rst_cnt", 64'(id_q_cnt_o), 64'd2);
        do_reset(1);
        @(negedge clk_i);
        check("rst_cnt", 64'(id_q_cnt_o), 64'd0);
        check("rst_rdy", 64'(id_stage_rdy_o), 64'd1);
        check("rst_vld", 64'(id_stage_vld_o), 64'd0);
        check("rst_pc", 64'(id_pc_o), 64'd0);
        step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(999) < 2) begin
                do_reset(1);
            end else begin
                if ($urandom_range(99) < 70) offer($urandom);
                else if_stage_vld_i = 1'b0;
                ex_stage_rdy_i = ($urandom_range(99) < 60);
                hazard_stall_i = ($urandom_range(99) < 15);
                flush_i        = ($urandom_range(99) < 3);
                step();
            end
        end

        zero_inputs();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/k423_id_inst_queue.md
# k423_id_inst_queue

Parametrised instruction queue at the front of the ID stage, between IF and the combinational decoder. It replaces the zero-storage IF→ID pass-through with a DEPTH-entry FIFO that carries each fetched instruction and its BPU prediction. The queue decouples fetch from EX back-pressure, holds instructions during load-use hazard stalls, and drops all in-flight entries on a pipeline flush. The decoder consumes the queue head.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk_i  in  1  core clock.
- rst_n_i  in  1  reset; synchronous, active-low.
- if_stage_vld_i  in  1  IF offers an instruction.
- id_stage_rdy_o  out  1  queue can accept an instruction.
- if_pc_i  in  `CORE_ADDR_W  PC of the offered instruction.
- if_inst_i  in  `CORE_INST_W  offered instruction word.
- if_bpu_prd_tkn_i  in  1  BPU predicted taken.
- if_bpu_prd_pc_i  in  `CORE_ADDR_W  BPU predicted target.
- if_bpu_prd_sat_cnt_i  in  2  BPU saturating counter.
- flush_i  in  1  discard all queued and offered instructions.
- hazard_stall_i  in  1  hold the head; do not present it to EX.
- id_stage_vld_o  out  1  head is valid toward EX.
- ex_stage_rdy_i  in  1  EX accepts the head.
- id_pc_o / id_inst_o / id_bpu_prd_tkn_o / id_bpu_prd_pc_o / id_bpu_prd_sat_cnt_o  out  as the matching inputs  head payload.
- id_q_cnt_o  out  CNT_W  current occupancy.

## Operation
- Enqueue fires when if_stage_vld_i & id_stage_rdy_o. The payload is written at wr_ptr, and wr_ptr advances.
- Dequeue fires when id_stage_vld_o & ex_stage_rdy_i, and rd_ptr advances.
- id_stage_rdy_o = (cnt != DEPTH). It depends only on registered state, with no combinational path from ex_stage_rdy_i. When the queue is full, it does not accept an instruction even if a dequeue happens in the same cycle.
- id_stage_vld_o = ~empty & ~hazard_stall_i & ~flush_i.
- Count update: +1 on enqueue only, −1 on dequeue only, unchanged when both or neither fire.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- flush_i has priority over everything. Next cycle: cnt=0 and rd_ptr=wr_ptr=0. A same-cycle enqueue is discarded and no dequeue occurs.
- hazard_stall_i freezes the head. Enqueue continues while there is space.
- Payload outputs always show the entry at rd_ptr. They are meaningful only while id_stage_vld_o=1.

## Timing
- Reset values: cnt, rd_ptr, wr_ptr = 0; all storage = 0; id_stage_vld_o=0; id_stage_rdy_o=1; all payload outputs = 0; id_q_cnt_o=0.
- Reset applied mid-operation behaves exactly like the reset case and also clears storage.
- Default latency: an instruction enqueued in cycle N is visible at the head, with id_stage_vld_o=1, in cycle N+1.
- Full throughput is 1 instruction/cycle in steady state when 0 < cnt < DEPTH.
- When full, the first dequeue reasserts id_stage_rdy_o in the following cycle.

## Configuration
- Macro K423_ID_QUEUE_BYPASS_EN.
- Defined: when the queue is empty and flush_i=0, the IF payload drives the id_* outputs combinationally, and id_stage_vld_o = if_stage_vld_i & ~hazard_stall_i.
  - If EX accepts in the same cycle, the entry is not written and cnt stays 0.
  - Otherwise it is written normally.
  - Latency is 0 cycles.
- Undefined: no bypass; 1-cycle latency as described under Timing.

## Structure
- Package k423_pkg holds:
  - typedef id_q_entry_t, a packed struct of pc, inst, prd_tkn, prd_pc, prd_sat_cnt;
  - constant K423_ID_Q_DEPTH_DFLT = 4.
- One sub-module: k423_fifo_ptr, which holds the rd/wr pointers, count, full/empty and flush clear. It is parametrised by DEPTH and reusable by a later EX/LSU queue.
- The storage array and output muxing stay in the top module.

## Test plan
- Reset, then push PCs 0x100, 0x104, 0x108, 0x10C with ex_stage_rdy_i=0 → id_q_cnt_o=4, id_stage_rdy_o=0, and id_pc_o=0x100 throughout.
- While full, set ex_stage_rdy_i=1 and keep if_stage_vld_i=1 → one cycle dequeues only (cnt=3). After that, simultaneous enqueue and dequeue each cycle keep cnt=3, and order is preserved across pointer wrap.
- Hold hazard_stall_i=1 for 3 cycles with head 0x200 and cnt=2 while pushing 0x20C → id_stage_vld_o=0, cnt=3, and 0x200 is issued first after release.
- Assert flush_i with cnt=3 and if_stage_vld_i=1 → id_stage_vld_o=0 that cycle, then cnt=0 and the next pushed PC 0x300 appears as head.
- With the bypass macro defined and the queue empty, push 0x400 with ex_stage_rdy_i=1 → id_pc_o=0x400 and id_stage_vld_o=1 in the same cycle, and cnt stays 0. Without the macro → it appears one cycle later.
- Apply rst_n_i=0 for 1 cycle at cnt=2 → all outputs return to their reset values on the next edge.
